// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, selector encodings and sequencer states for the 4-bit CPU
package cpu_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LDA_A  = 4'h1;
    localparam logic [3:0] OP_LDA_B  = 4'h2;
    localparam logic [3:0] OP_LDA_IN = 4'h3;
    localparam logic [3:0] OP_LDA_Z  = 4'h4;
    localparam logic [3:0] OP_LDB_A  = 4'h5;
    localparam logic [3:0] OP_LDB_B  = 4'h6;
    localparam logic [3:0] OP_LDB_IN = 4'h7;
    localparam logic [3:0] OP_LDB_Z  = 4'h8;
    localparam logic [3:0] OP_OUT_B  = 4'h9;
    localparam logic [3:0] OP_OUT_Z  = 4'hA;
    localparam logic [3:0] OP_JMP    = 4'hB;
    localparam logic [3:0] OP_JNC    = 4'hC;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_IN   = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef enum logic [1:0] {
        ST_HALT,
        ST_FETCH,
        ST_EXEC
    } state_t;

endpackage

// File: rtl/insn_decode.sv
// rtl/insn_decode.sv - combinational opcode decode into load strobes, bus select and legality
module insn_decode
    import cpu_pkg::*;
(
    input  logic [3:0] OP,
    input  logic       C,
    output logic       LD_A,
    output logic       LD_B,
    output logic       LD_out,
    output logic       LD_PC,
    output logic [1:0] S,
    output logic       legal
);

    always_comb begin
        LD_A   = 1'b0;
        LD_B   = 1'b0;
        LD_out = 1'b0;
        LD_PC  = 1'b0;
        S      = SEL_A;
        legal  = 1'b1;
        case (OP)
            OP_NOP:    ;
            OP_LDA_A:  begin LD_A = 1'b1;   S = SEL_A;    end
            OP_LDA_B:  begin LD_A = 1'b1;   S = SEL_B;    end
            OP_LDA_IN: begin LD_A = 1'b1;   S = SEL_IN;   end
            OP_LDA_Z:  begin LD_A = 1'b1;   S = SEL_ZERO; end
            OP_LDB_A:  begin LD_B = 1'b1;   S = SEL_A;    end
            OP_LDB_B:  begin LD_B = 1'b1;   S = SEL_B;    end
            OP_LDB_IN: begin LD_B = 1'b1;   S = SEL_IN;   end
            OP_LDB_Z:  begin LD_B = 1'b1;   S = SEL_ZERO; end
            OP_OUT_B:  begin LD_out = 1'b1; S = SEL_B;    end
            OP_OUT_Z:  begin LD_out = 1'b1; S = SEL_ZERO; end
            OP_JMP:    begin LD_PC = 1'b1;  S = SEL_ZERO; end
            OP_JNC: begin
                // carry set: falls through as a NOP that still advances the PC
                if (!C) begin
                    LD_PC = 1'b1;
                    S     = SEL_ZERO;
                end
            end
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - FETCH/EXEC run-control sequencer with step, halt, breakpoint and trap
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic       CK,
    input  logic       RST_N,
    input  logic       RUN,
    input  logic       STEP,
    input  logic       HALT_REQ,
    input  logic       BP_EN,
    input  logic [3:0] BP_ADDR,
    input  logic [3:0] PC,
    input  logic [7:0] ROM_Q,
    input  logic       CARRY,
    output logic [3:0] IM,
    output logic       LD_A,
    output logic       LD_B,
    output logic       LD_out,
    output logic       LD_PC,
    output logic [1:0] S,
    output logic       PC_EN,
    output logic       C_FLAG,
    output logic       HALTED,
    output logic       BP_HIT,
    output logic       ILLEGAL,
    output logic [7:0] RETIRED
);

    state_t     state;
    logic [7:0] ir;
    logic       c_flag;
    logic       bp_hit;
    logic       illegal;
    logic       skip;
    logic       step_mode;
    logic       step_q;
    logic [7:0] retired;

    logic       dec_ld_a, dec_ld_b, dec_ld_out, dec_ld_pc, dec_legal;
    logic [1:0] dec_s;
    logic       in_exec;
    logic       step_rise;

    insn_decode u_decode (
        .OP     (ir[7:4]),
        .C      (c_flag),
        .LD_A   (dec_ld_a),
        .LD_B   (dec_ld_b),
        .LD_out (dec_ld_out),
        .LD_PC  (dec_ld_pc),
        .S      (dec_s),
        .legal  (dec_legal)
    );

    assign in_exec   = (state == ST_EXEC);
    assign step_rise = STEP & ~step_q;

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_HALT;
            ir        <= 8'h00;
            c_flag    <= 1'b0;
            bp_hit    <= 1'b0;
            illegal   <= 1'b0;
            skip      <= 1'b0;
            step_mode <= 1'b0;
            step_q    <= 1'b0;
            retired   <= 8'h00;
        end else begin
            step_q <= STEP;
            case (state)
                ST_HALT: begin
                    if (!illegal && (RUN || step_rise)) begin
                        state     <= ST_FETCH;
                        skip      <= 1'b1;
                        bp_hit    <= 1'b0;
                        step_mode <= ~RUN;
                    end
                end
                ST_FETCH: begin
                    // skip lets a resume at the breakpoint address run that instruction
                    if (BP_EN && (PC == BP_ADDR) && !skip) begin
                        state  <= ST_HALT;
                        bp_hit <= 1'b1;
                    end else begin
                        ir    <= ROM_Q;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    skip <= 1'b0;
                    if (!dec_legal) begin
                        illegal <= 1'b1;
                        state   <= ST_HALT;
                    end else begin
                        c_flag  <= CARRY;
                        retired <= retired + 8'd1;
                        if (step_mode || HALT_REQ || !RUN)
                            state <= ST_HALT;
                        else
                            state <= ST_FETCH;
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end

    assign LD_A    = in_exec & dec_ld_a;
    assign LD_B    = in_exec & dec_ld_b;
    assign LD_out  = in_exec & dec_ld_out;
    assign LD_PC   = in_exec & dec_ld_pc;
    assign S       = in_exec ? dec_s : SEL_A;
    assign PC_EN   = in_exec & dec_legal;

    assign IM      = ir[3:0];
    assign C_FLAG  = c_flag;
    assign HALTED  = (state == ST_HALT);
    assign BP_HIT  = bp_hit;
    assign ILLEGAL = illegal;
    assign RETIRED = retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

    logic       CK = 1'b0;
    logic       RST_N = 1'b0;
    logic       RUN = 1'b0;
    logic       STEP = 1'b0;
    logic       HALT_REQ = 1'b0;
    logic       BP_EN = 1'b0;
    logic [3:0] BP_ADDR = 4'h0;
    logic       CARRY = 1'b0;
    logic [3:0] pc;
    logic [7:0] rom [16];
    logic [7:0] rom_q;

    logic [3:0] IM;
    logic       LD_A, LD_B, LD_out, LD_PC, PC_EN, C_FLAG, HALTED, BP_HIT, ILLEGAL;
    logic [1:0] S;
    logic [7:0] RETIRED;

    int n_cmp = 0;
    int n_err = 0;
    int busy;

    cpu_sequencer dut (
        .CK       (CK),
        .RST_N    (RST_N),
        .RUN      (RUN),
        .STEP     (STEP),
        .HALT_REQ (HALT_REQ),
        .BP_EN    (BP_EN),
        .BP_ADDR  (BP_ADDR),
        .PC       (pc),
        .ROM_Q    (rom_q),
        .CARRY    (CARRY),
        .IM       (IM),
        .LD_A     (LD_A),
        .LD_B     (LD_B),
        .LD_out   (LD_out),
        .LD_PC    (LD_PC),
        .S        (S),
        .PC_EN    (PC_EN),
        .C_FLAG   (C_FLAG),
        .HALTED   (HALTED),
        .BP_HIT   (BP_HIT),
        .ILLEGAL  (ILLEGAL),
        .RETIRED  (RETIRED)
    );

    always #5 CK = ~CK;

    assign rom_q = rom[pc];

    // program counter of the surrounding core
    always @(posedge CK or negedge RST_N) begin
        if (!RST_N)
            pc <= 4'h0;
        else if (PC_EN)
            pc <= LD_PC ? IM : pc + 4'd1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] strobes();
        return {3'b000, LD_A, LD_B, LD_out, LD_PC, PC_EN};
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = 8'h47;
        rom[1] = 8'hC5;
        rom[2] = 8'hC5;
        rom[3] = 8'h9F;
        rom[6] = 8'hB2;

        // reset state
        repeat (2) @(negedge CK);
        chk("rst_halted", HALTED, 1);
        chk("rst_strobes", strobes(), 0);
        chk("rst_s", S, 0);
        chk("rst_im", IM, 0);
        chk("rst_retired", RETIRED, 0);
        chk("rst_flags", {C_FLAG, BP_HIT, ILLEGAL}, 0);

        // LD_A zero, 8'h47
        RST_N = 1'b1;
        RUN = 1'b1;
        @(negedge CK);
        chk("t1_fetch_halted", HALTED, 0);
        chk("t1_fetch_strobes", strobes(), 0);
        @(negedge CK);
        chk("t1_exec_strobes", strobes(), 8'b0001_0001);
        chk("t1_exec_s", S, 2'b11);
        chk("t1_exec_im", IM, 7);
        chk("t1_exec_retired", RETIRED, 0);
        RUN = 1'b0;
        CARRY = 1'b1;
        @(negedge CK);
        chk("t1_retired", RETIRED, 1);
        chk("t1_halted", HALTED, 1);
        chk("t1_cflag", C_FLAG, 1);
        chk("t1_pc", pc, 1);

        // JNC with carry set: not taken
        CARRY = 1'b0;
        STEP = 1'b1;
        @(negedge CK);
        chk("jnc1_fetch", HALTED, 0);
        @(negedge CK);
        chk("jnc1_exec_strobes", strobes(), 8'b0000_0001);
        @(negedge CK);
        chk("jnc1_halted", HALTED, 1);
        chk("jnc1_cflag", C_FLAG, 0);
        chk("jnc1_pc", pc, 2);
        STEP = 1'b0;
        @(negedge CK);

        // JNC with carry clear: taken to 5
        STEP = 1'b1;
        @(negedge CK);
        @(negedge CK);
        chk("jnc0_exec_strobes", strobes(), 8'b0000_0011);
        chk("jnc0_exec_s", S, 2'b11);
        chk("jnc0_exec_im", IM, 5);
        @(negedge CK);
        chk("jnc0_halted", HALTED, 1);
        chk("jnc0_pc", pc, 5);
        chk("jnc0_retired", RETIRED, 3);
        STEP = 1'b0;
        @(negedge CK);

        // STEP held for 10 cycles runs exactly one instruction
        STEP = 1'b1;
        busy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CK);
            if (!HALTED) busy++;
        end
        STEP = 1'b0;
        chk("step_busy_cycles", busy[7:0], 2);
        chk("step_retired", RETIRED, 4);
        chk("step_halted", HALTED, 1);
        chk("step_pc", pc, 6);

        // breakpoint at PC 3: JMP 2, JNC (carry set, falls through), abort at 3
        BP_EN = 1'b1;
        BP_ADDR = 4'd3;
        CARRY = 1'b1;
        RUN = 1'b1;
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CK);
            busy++;
            if (HALTED) break;
        end
        RUN = 1'b0;
        chk("bp_cycles", busy[7:0], 6);
        chk("bp_halted", HALTED, 1);
        chk("bp_hit", BP_HIT, 1);
        chk("bp_ir_kept", IM, 5);
        chk("bp_retired", RETIRED, 6);
        chk("bp_pc", pc, 3);
        @(negedge CK);
        chk("bp_stays_halted", HALTED, 1);

        // resume executes the instruction at the breakpoint
        RUN = 1'b1;
        @(negedge CK);
        chk("resume_bp_clear", BP_HIT, 0);
        chk("resume_fetch", HALTED, 0);
        @(negedge CK);
        chk("resume_exec_strobes", strobes(), 8'b0000_0101);
        chk("resume_exec_s", S, 2'b01);
        @(negedge CK);
        chk("resume_running", HALTED, 0);
        chk("resume_retired", RETIRED, 7);
        // RUN drops during FETCH: the instruction still completes
        RUN = 1'b0;
        @(negedge CK);
        chk("rundrop_exec", strobes(), 8'b0000_0001);
        @(negedge CK);
        chk("rundrop_halted", HALTED, 1);
        chk("rundrop_retired", RETIRED, 8);

        // HALT_REQ stops after one instruction while RUN stays high
        RUN = 1'b1;
        HALT_REQ = 1'b1;
        repeat (3) @(negedge CK);
        chk("hreq_halted", HALTED, 1);
        chk("hreq_retired", RETIRED, 9);
        chk("hreq_pc", pc, 6);
        RUN = 1'b0;
        HALT_REQ = 1'b0;

        // illegal opcode trap
        rom[6] = 8'hD0;
        @(negedge CK);
        RUN = 1'b1;
        @(negedge CK);
        @(negedge CK);
        chk("ill_exec_strobes", strobes(), 0);
        chk("ill_exec_s", S, 0);
        @(negedge CK);
        chk("ill_halted", HALTED, 1);
        chk("ill_flag", ILLEGAL, 1);
        chk("ill_retired", RETIRED, 9);
        chk("ill_cflag", C_FLAG, 1);
        chk("ill_pc", pc, 6);
        repeat (3) @(negedge CK);
        STEP = 1'b1;
        repeat (3) @(negedge CK);
        chk("ill_ignores_run_step", HALTED, 1);
        STEP = 1'b0;
        RUN = 1'b0;
        RST_N = 1'b0;
        @(negedge CK);
        chk("ill_cleared", ILLEGAL, 0);

        // async reset in the middle of EXEC
        CARRY = 1'b1;
        RST_N = 1'b1;
        RUN = 1'b1;
        repeat (4) @(negedge CK);
        chk("mid_exec_strobes", strobes(), 8'b0000_0001);
        chk("mid_retired", RETIRED, 1);
        chk("mid_cflag", C_FLAG, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_halted", HALTED, 1);
        chk("arst_strobes", strobes(), 0);
        chk("arst_retired", RETIRED, 0);
        chk("arst_cflag", C_FLAG, 0);
        chk("arst_im", IM, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
